// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// MULTDIV_BOOTH_RADIX4_EN selects the radix-4 Booth multiplier (WIDTH/2 cycles).
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int mult_cycles(input int width);
`ifdef MULTDIV_BOOTH_RADIX4_EN
    return width / 2;
`else
    return width;
`endif
  endfunction

  function automatic int div_cycles(input int width);
    return width;
  endfunction

  localparam int MULT_CYCLES = mult_cycles(32);
  localparam int DIV_CYCLES  = div_cycles(32);

  // Status codes that writeback places in $rstatus when data_exception is set.
  localparam logic [31:0] EXC_CODE_MULT = 32'd4;
  localparam logic [31:0] EXC_CODE_DIV  = 32'd5;

endpackage

// File: rtl/multdiv_div_step.sv
// One combinational iteration of unsigned restoring division:
// shift the next dividend bit into the remainder and subtract the divisor if it fits.
module multdiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_q
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_trial;

  // With i_rem < i_divisor the trial difference is below 2^WIDTH when it fits,
  // so its top bit acts as the borrow.
  assign w_shifted = {i_rem, i_bit};
  assign w_trial   = w_shifted - {1'b0, i_divisor};
  assign o_q       = ~w_trial[WIDTH];
  assign o_rem     = o_q ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide execute unit with a one-cycle ready pulse.
// Define MULTDIV_BOOTH_RADIX4_EN for radix-4 Booth multiply; default is radix-2 shift-add.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(mult_cycles(WIDTH) - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(div_cycles(WIDTH) - 1);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [WIDTH-1:0]   r_mag_b;
  logic               r_sign;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_result;
  logic               r_exc;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic               w_mul_last;
  logic               w_div_last;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH:0]     w_prod_hi;
  logic [WIDTH-1:0]   w_div_rem;
  logic               w_div_q;
  logic [2*WIDTH-1:0] w_div_next;
  logic [WIDTH-1:0]   w_quo_mag;
  logic               w_div_zero;
  logic               w_div_ovf;

  // Magnitudes are WIDTH-bit unsigned, so the most negative value maps to 2^(WIDTH-1).
  assign w_mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign w_mul_last = (r_cnt == MUL_LAST);
  assign w_div_last = (r_cnt == DIV_LAST);

  // ---------------------------------------------------------------- FSM
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking (=) belongs only in combinational blocks.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: every combinational output gets a default before the case, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (ctrl_MULT) begin
          w_next = MUL;
        end else if (ctrl_DIV) begin
          w_next = DIV;
        end
      end
      MUL:     if (w_mul_last) w_next = DONE;
      DIV:     if (w_div_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    data_resultRDY = (r_state == DONE);
    busy           = (r_state == MUL) || (r_state == DIV);
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;

  // ---------------------------------------------------------------- multiply datapath
`ifdef MULTDIV_BOOTH_RADIX4_EN
  logic [2*WIDTH-1:0] r_bth_mcand;
  logic [WIDTH-1:0]   r_bth_mplier;
  logic               r_bth_prev;
  logic [2:0]         w_bth_sel;
  logic [2*WIDTH-1:0] w_bth_add;

  // Booth digit from multiplier bits {2i+1, 2i, 2i-1}: one of 0, +-1, +-2 times A*4^i.
  assign w_bth_sel = {r_bth_mplier[1:0], r_bth_prev};

  always_comb begin
    w_bth_add = '0;
    case (w_bth_sel)
      3'b001, 3'b010: w_bth_add = r_bth_mcand;
      3'b011:         w_bth_add = r_bth_mcand << 1;
      3'b100:         w_bth_add = -(r_bth_mcand << 1);
      3'b101, 3'b110: w_bth_add = -r_bth_mcand;
      default:        w_bth_add = '0;
    endcase
  end

  assign w_mul_next = r_acc + w_bth_add;
  assign w_prod     = w_mul_next;
`else
  logic [WIDTH-1:0] r_mag_a;
  logic [WIDTH:0]   w_mul_sum;

  // r_acc = {partial product high half, remaining multiplier bits}; shifts right each step.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_prod     = r_sign ? -w_mul_next : w_mul_next;
`endif

  // The product fits in WIDTH signed bits only if its top WIDTH+1 bits are a sign extension.
  assign w_prod_hi = w_prod[2*WIDTH-1:WIDTH-1];

  // ---------------------------------------------------------------- divide datapath
  multdiv_div_step #(
    .WIDTH (WIDTH)
  ) u_div_step (
    .i_rem     (r_acc[2*WIDTH-1:WIDTH]),
    .i_divisor (r_mag_b),
    .i_bit     (r_acc[WIDTH-1]),
    .o_rem     (w_div_rem),
    .o_q       (w_div_q)
  );

  // r_acc = {remainder, dividend bits still to consume / quotient bits produced so far}.
  assign w_div_next = {w_div_rem, r_acc[WIDTH-2:0], w_div_q};
  assign w_quo_mag  = w_div_next[WIDTH-1:0];
  assign w_div_zero = (r_op_b == '0);
  assign w_div_ovf  = (r_op_a == MIN_VAL) && (r_op_b == '1);

  // NOTE: datapath registers are reset as well, so data_result/data_exception read 0
  // immediately after reset rather than holding stale values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_mag_b      <= '0;
      r_sign       <= 1'b0;
      r_acc        <= '0;
      r_result     <= '0;
      r_exc        <= 1'b0;
`ifdef MULTDIV_BOOTH_RADIX4_EN
      r_bth_mcand  <= '0;
      r_bth_mplier <= '0;
      r_bth_prev   <= 1'b0;
`else
      r_mag_a      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (ctrl_MULT || ctrl_DIV) begin
            r_cnt   <= '0;
            r_op_a  <= data_operandA;
            r_op_b  <= data_operandB;
            r_mag_b <= w_mag_b;
            r_sign  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            if (ctrl_MULT) begin
`ifdef MULTDIV_BOOTH_RADIX4_EN
              r_acc        <= '0;
              r_bth_mcand  <= {{WIDTH{data_operandA[WIDTH-1]}}, data_operandA};
              r_bth_mplier <= data_operandB;
              r_bth_prev   <= 1'b0;
`else
              r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
              r_mag_a <= w_mag_a;
`endif
            end else begin
              r_acc <= {{WIDTH{1'b0}}, w_mag_a};
            end
          end
        end
        MUL: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_mul_next;
`ifdef MULTDIV_BOOTH_RADIX4_EN
          r_bth_mcand  <= r_bth_mcand << 2;
          r_bth_mplier <= r_bth_mplier >> 2;
          r_bth_prev   <= r_bth_mplier[1];
`endif
          if (w_mul_last) begin
            r_result <= w_prod[WIDTH-1:0];
            r_exc    <= ~((&w_prod_hi) | ~(|w_prod_hi));
          end
        end
        DIV: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_acc <= w_div_next;
          if (w_div_last) begin
            if (w_div_zero) begin
              r_result <= '0;
              r_exc    <= 1'b1;
            end else if (w_div_ovf) begin
              r_result <= MIN_VAL;
              r_exc    <= 1'b1;
            end else begin
              r_result <= r_sign ? -w_quo_mag : w_quo_mag;
              r_exc    <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed vector table, multi-cycle corner
// sequences, and randomized operations against an arithmetic reference model.
module tb_multdiv_unit;

`ifdef MULTDIV_BOOTH_RADIX4_EN
  localparam int MUL_LAT = 17;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int WINDOW  = 40;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  multdiv_unit #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          mult;
    bit          div;
    logic [31:0] exp_res;
    bit          exp_exc;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic on 64-bit integers.
  function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input bit m,
                                    output logic [31:0] r, output bit e);
    int     sa;
    int     sb;
    longint p;
    sa = a;
    sb = b;
    if (m) begin
      p = longint'(sa) * longint'(sb);
      r = p[31:0];
      e = (p != longint'(int'(p[31:0])));
    end else if (sb == 0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (sa == 32'sh8000_0000 && sb == -1) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = sa / sb;
      e = 1'b0;
    end
  endfunction

  // Issue one operation, watch WINDOW cycles, optionally pulse a start line at inj_cyc.
  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input bit m, input bit d, input logic [31:0] exp_res,
                               input bit exp_exc, input int inj_cyc, input bit inj_m,
                               input bit inj_d);
    logic [31:0] res;
    logic        exc;
    int          rdy_cyc;
    int          rdy_cnt;
    int          lat;
    bit          busy_ok;
    lat     = m ? MUL_LAT : DIV_LAT;
    res     = 'x;
    exc     = 1'bx;
    rdy_cyc = -1;
    rdy_cnt = 0;
    busy_ok = 1'b1;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    for (int c = 1; c <= WINDOW; c++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          res     = data_result;
          exc     = data_exception;
        end
      end
      if (busy !== (c < lat)) busy_ok = 1'b0;
      if (c == inj_cyc) begin
        data_operandA = 32'h0000_0009;
        data_operandB = 32'h0000_0002;
        ctrl_MULT     = inj_m;
        ctrl_DIV      = inj_d;
      end else if (c == inj_cyc + 1) begin
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
      end
    end
    check({tag, "_result"}, res, exp_res);
    check({tag, "_exception"}, exc, exp_exc);
    check({tag, "_rdy_cycle"}, rdy_cyc, lat);
    check({tag, "_rdy_count"}, rdy_cnt, 1);
    check({tag, "_busy_window"}, busy_ok, 1'b1);
  endtask

  vec_t vecs[15];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] er;
    bit          ee;
    bit          rm;
    bit          rd;
    int          sel;

    vecs[0]  = '{32'd7,         32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0000_0001, 1'b0};
    vecs[3]  = '{32'hFFFF_FFF9, 32'd2,         1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'd14,        1'b0};
    vecs[5]  = '{32'd5,         32'd0,         1'b0, 1'b1, 32'd0,         1'b1};
    vecs[6]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1};
    vecs[7]  = '{32'd3,         32'd4,         1'b1, 1'b0, 32'd12,        1'b0};
    vecs[8]  = '{32'd6,         32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFF4, 1'b0};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[10] = '{32'h8000_0000, 32'd1,         1'b1, 1'b0, 32'h8000_0000, 1'b0};
    vecs[11] = '{32'h8000_0000, 32'd1,         1'b0, 1'b1, 32'h8000_0000, 1'b0};
    vecs[12] = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, 1'b1, 32'd14,        1'b0};
    vecs[13] = '{32'd7,         32'hFFFF_FFFD, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vecs[14] = '{32'h7FFF_FFFF, 32'd2,         1'b1, 1'b0, 32'hFFFF_FFFE, 1'b1};

    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    reset         = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("reset_result", data_result, 32'd0);
    check("reset_exception", data_exception, 1'b0);
    check("reset_rdy", data_resultRDY, 1'b0);
    check("reset_busy", busy, 1'b0);

    for (int i = 0; i < 15; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].mult, vecs[i].div,
                    vecs[i].exp_res, vecs[i].exp_exc, 0, 1'b0, 1'b0);
    end

    // Reset wins over a start pulse in the same cycle.
    @(negedge clock);
    data_operandA = 32'd3;
    data_operandB = 32'd4;
    ctrl_MULT     = 1'b1;
    reset         = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    reset     = 1'b0;
    @(negedge clock);
    check("reset_vs_start_busy", busy, 1'b0);
    repeat (3) @(negedge clock);
    check("reset_vs_start_busy_later", busy, 1'b0);

    // Start pulses while busy and in the DONE cycle are ignored.
    run_and_check("div_while_mult", 32'd3, 32'd4, 1'b1, 1'b0, 32'd12, 1'b0, 10, 1'b0, 1'b1);
    run_and_check("mult_while_div", 32'd100, 32'd7, 1'b0, 1'b1, 32'd14, 1'b0, 20, 1'b1, 1'b0);
    run_and_check("mult_in_done", 32'd3, 32'd4, 1'b1, 1'b0, 32'd12, 1'b0, MUL_LAT, 1'b1, 1'b0);

    // Leave non-zero outputs, then abort a divide with reset at cycle 15.
    run_and_check("pre_abort", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1,
                  0, 1'b0, 1'b0);
    @(negedge clock);
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clock);
      if (c == 14) check("abort_busy_before", busy, 1'b1);
    end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_result", data_result, 32'd0);
    check("abort_exception", data_exception, 1'b0);
    check("abort_rdy", data_resultRDY, 1'b0);
    check("abort_busy", busy, 1'b0);
    run_and_check("after_abort", 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b0,
                  0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 7);
      ra  = $urandom;
      rb  = $urandom;
      case (sel)
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: begin
          ra = $urandom_range(0, 200) - 100;
          rb = $urandom_range(0, 40) - 20;
        end
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      rm = $urandom_range(0, 1);
      rd = rm ? ($urandom_range(0, 3) == 0) : 1'b1;
      ref_model(ra, rb, rm, er, ee);
      run_and_check($sformatf("rand%0d", i), ra, rb, rm, rd, er, ee, 0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
